// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the address-phase bundle used by the master mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahbl_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic        write;
   } aph_t;

endpackage

// File: rtl/ahbl_hold_stage.sv
// Parks one master's address phase after it loses arbitration or arrives during a wait state.
// Latency: captured on the edge, visible as hold_valid from the next cycle.
// Backpressure: hold_valid stalls the owning master until the held phase is granted.
module ahbl_hold_stage
   import ahbl_pkg::*;
(
   input  logic HCLK,
   input  logic HRESETn,
   input  logic capture,
   input  logic clear,
   input  aph_t live_aph,
   output logic hold_valid,
   output aph_t hold_aph
);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_valid <= 1'b0;
         hold_aph   <= '0;
      end else if (capture) begin
         hold_valid <= 1'b1;
         hold_aph   <= live_aph;
      end else if (clear) begin
         hold_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ahbl_master_mux2.sv
// Two-master AHB-Lite arbiter/mux: CPU (m0) and DMA (m1) share one downstream bus.
// Latency: live grant adds 0 cycles; a captured request adds at least 1 cycle.
// Backpressure: losers and wait-state arrivals are held and stalled through their own HREADY.
module ahbl_master_mux2
   import ahbl_pkg::*;
#(
   parameter int PRIO_MODE = PRIO_RR
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] m0HADDR,
   input  logic [1:0]  m0HTRANS,
   input  logic [2:0]  m0HSIZE,
   input  logic        m0HWRITE,
   input  logic [31:0] m0HWDATA,
   output logic        m0HREADY,
   output logic [31:0] m0HRDATA,
   input  logic [31:0] m1HADDR,
   input  logic [1:0]  m1HTRANS,
   input  logic [2:0]  m1HSIZE,
   input  logic        m1HWRITE,
   input  logic [31:0] m1HWDATA,
   output logic        m1HREADY,
   output logic [31:0] m1HRDATA,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA
);

   aph_t       live_aph [2];
   aph_t       hold_aph [2];
   logic [1:0] mtrans   [2];
   logic [1:0] hold_valid;
   logic [1:0] mready, live_req, req, capture, clear;
   logic       gnt_vld, gnt_idx;
   aph_t       gnt_aph, out_aph_r;
   logic [1:0] gnt_trans;
   logic       dph_valid, dph_owner, last_grant;

   assign live_aph[0] = {m0HADDR, m0HSIZE, m0HWRITE};
   assign live_aph[1] = {m1HADDR, m1HSIZE, m1HWRITE};
   assign mtrans[0]   = m0HTRANS;
   assign mtrans[1]   = m1HTRANS;

   ahbl_hold_stage u_hold0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .capture(capture[0]), .clear(clear[0]),
      .live_aph(live_aph[0]), .hold_valid(hold_valid[0]), .hold_aph(hold_aph[0])
   );

   ahbl_hold_stage u_hold1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .capture(capture[1]), .clear(clear[1]),
      .live_aph(live_aph[1]), .hold_valid(hold_valid[1]), .hold_aph(hold_aph[1])
   );

   always_comb begin
      mready   = 2'b11;
      live_req = 2'b00;
      req      = 2'b00;
      for (int m = 0; m < 2; m++) begin
         if (dph_valid && dph_owner == 1'(m)) mready[m] = HREADY;
         else if (hold_valid[m])              mready[m] = 1'b0;
         live_req[m] = mtrans[m][1] & mready[m];
         req[m]      = hold_valid[m] | live_req[m];
      end

      // A tie in round-robin goes to whoever was not granted last.
      if (req == 2'b11) gnt_idx = (PRIO_MODE == PRIO_FIXED) ? 1'b1 : ~last_grant;
      else              gnt_idx = req[1];
      gnt_vld   = HREADY & (|req);
      gnt_aph   = hold_valid[gnt_idx] ? hold_aph[gnt_idx] : live_aph[gnt_idx];
      gnt_trans = hold_valid[gnt_idx] ? HTRANS_NONSEQ : mtrans[gnt_idx];

      for (int m = 0; m < 2; m++) begin
         capture[m] = live_req[m] & ~(gnt_vld & (gnt_idx == 1'(m)));
         clear[m]   = gnt_vld & (gnt_idx == 1'(m)) & hold_valid[m];
      end
   end

   always_comb begin
      HADDR  = out_aph_r.addr;
      HSIZE  = out_aph_r.size;
      HWRITE = out_aph_r.write;
      HTRANS = HTRANS_IDLE;
      if (gnt_vld) begin
         HADDR  = gnt_aph.addr;
         HSIZE  = gnt_aph.size;
         HWRITE = gnt_aph.write;
         HTRANS = gnt_trans;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dph_valid  <= 1'b0;
         dph_owner  <= 1'b0;
         last_grant <= 1'b1;
         out_aph_r  <= '0;
      end else if (HREADY) begin
         dph_valid <= gnt_vld;
         dph_owner <= gnt_idx;
         if (gnt_vld) begin
            last_grant <= gnt_idx;
            out_aph_r  <= gnt_aph;
         end
      end
   end

   assign HWDATA   = dph_owner ? m1HWDATA : m0HWDATA;
   assign m0HREADY = mready[0];
   assign m1HREADY = mready[1];
   assign m0HRDATA = HRDATA;
   assign m1HRDATA = HRDATA;

endmodule

// File: tb/tb_ahbl_master_mux2.sv
// Directed and randomized bench for ahbl_master_mux2; one round-robin and one fixed-priority
// instance share the same master/slave stimulus, the random section is scored on the round-robin one.
module tb_ahbl_master_mux2;
   import ahbl_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] m0HADDR, m1HADDR, m0HWDATA, m1HWDATA, HRDATA;
   logic [1:0]  m0HTRANS, m1HTRANS;
   logic [2:0]  m0HSIZE, m1HSIZE;
   logic        m0HWRITE, m1HWRITE, HREADY;

   logic        d0_m0HREADY, d0_m1HREADY, d0_HWRITE, d1_m0HREADY, d1_m1HREADY, d1_HWRITE;
   logic [31:0] d0_m0HRDATA, d0_m1HRDATA, d0_HADDR, d0_HWDATA;
   logic [31:0] d1_m0HRDATA, d1_m1HRDATA, d1_HADDR, d1_HWDATA;
   logic [1:0]  d0_HTRANS, d1_HTRANS;
   logic [2:0]  d0_HSIZE, d1_HSIZE;

   int n_cmp = 0;
   int n_err = 0;

   always #5 HCLK = ~HCLK;

   ahbl_master_mux2 #(.PRIO_MODE(PRIO_RR)) dut_rr (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .m0HADDR(m0HADDR), .m0HTRANS(m0HTRANS), .m0HSIZE(m0HSIZE), .m0HWRITE(m0HWRITE),
      .m0HWDATA(m0HWDATA), .m0HREADY(d0_m0HREADY), .m0HRDATA(d0_m0HRDATA),
      .m1HADDR(m1HADDR), .m1HTRANS(m1HTRANS), .m1HSIZE(m1HSIZE), .m1HWRITE(m1HWRITE),
      .m1HWDATA(m1HWDATA), .m1HREADY(d0_m1HREADY), .m1HRDATA(d0_m1HRDATA),
      .HADDR(d0_HADDR), .HTRANS(d0_HTRANS), .HSIZE(d0_HSIZE), .HWRITE(d0_HWRITE),
      .HWDATA(d0_HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
   );

   ahbl_master_mux2 #(.PRIO_MODE(PRIO_FIXED)) dut_fx (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .m0HADDR(m0HADDR), .m0HTRANS(m0HTRANS), .m0HSIZE(m0HSIZE), .m0HWRITE(m0HWRITE),
      .m0HWDATA(m0HWDATA), .m0HREADY(d1_m0HREADY), .m0HRDATA(d1_m0HRDATA),
      .m1HADDR(m1HADDR), .m1HTRANS(m1HTRANS), .m1HSIZE(m1HSIZE), .m1HWRITE(m1HWRITE),
      .m1HWDATA(m1HWDATA), .m1HREADY(d1_m1HREADY), .m1HRDATA(d1_m1HRDATA),
      .HADDR(d1_HADDR), .HTRANS(d1_HTRANS), .HSIZE(d1_HSIZE), .HWRITE(d1_HWRITE),
      .HWDATA(d1_HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int m, input logic [1:0] t, input logic [31:0] a,
                        input logic w, input logic [31:0] wd);
      if (m == 0) begin
         m0HTRANS = t; m0HADDR = a; m0HWRITE = w; m0HSIZE = 3'd2; m0HWDATA = wd;
      end else begin
         m1HTRANS = t; m1HADDR = a; m1HWRITE = w; m1HSIZE = 3'd2; m1HWDATA = wd;
      end
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      HREADY  = 1'b1;
      HRDATA  = 32'h0;
      set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
   endtask

   // Transaction-level model of two AHB masters, a memory-like slave and the shared bus.
   typedef struct {
      logic        v;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   xfer_t cur [2];   // transfer a master is presenting in its address phase
   xfer_t dph [2];   // transfer in the master's own data phase
   xfer_t pend[2];   // accepted by the master side but not yet seen on the shared bus
   xfer_t bus;       // transfer in the shared bus data phase
   int    bus_m;
   int    skip[2];
   int    gnt_log[$];

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   function automatic xfer_t gen(input logic mi, input int pct);
      xfer_t x;
      logic [31:0] r;
      r       = $urandom;
      x.v     = (int'($urandom_range(99)) < pct);
      x.addr  = {mi, r[30:2], 2'b00};
      x.wr    = r[1];
      x.size  = 3'(r[0] ? 2 : 1);
      x.wdata = $urandom;
      return x;
   endfunction

   task automatic eng_init(input int pct);
      for (int m = 0; m < 2; m++) begin
         cur[m]  = gen(1'(m), pct);
         dph[m]  = gen(1'(m), 0);
         pend[m] = gen(1'(m), 0);
         skip[m] = 0;
      end
      bus   = gen(1'b0, 0);
      bus_m = 0;
   endtask

   task automatic step(input int req_pct, input int rdy_pct);
      logic        r [2];
      logic [31:0] rd [2];
      logic [31:0] haddr;
      logic [1:0]  htrans;
      logic        hwrite, exp_r;
      logic [2:0]  hsize;
      int          bm;
      HREADY   = (int'($urandom_range(99)) < rdy_pct);
      HRDATA   = rd_fn(bus.addr);
      m0HTRANS = cur[0].v ? HTRANS_NONSEQ : HTRANS_IDLE;
      m0HADDR  = cur[0].addr; m0HWRITE = cur[0].wr; m0HSIZE = cur[0].size; m0HWDATA = dph[0].wdata;
      m1HTRANS = cur[1].v ? HTRANS_NONSEQ : HTRANS_IDLE;
      m1HADDR  = cur[1].addr; m1HWRITE = cur[1].wr; m1HSIZE = cur[1].size; m1HWDATA = dph[1].wdata;
      @(negedge HCLK);
      r[0] = d0_m0HREADY; r[1] = d0_m1HREADY;
      rd[0] = d0_m0HRDATA; rd[1] = d0_m1HRDATA;
      haddr = d0_HADDR; htrans = d0_HTRANS; hwrite = d0_HWRITE; hsize = d0_HSIZE;
      for (int m = 0; m < 2; m++) begin
         exp_r = (bus.v && bus_m == m) ? HREADY : !pend[m].v;
         chkb("rnd_mready", r[m], exp_r);
      end
      if (!HREADY) chk("rnd_wait_idle", 32'(htrans), 32'(HTRANS_IDLE));
      if (bus.v && bus.wr) chk("rnd_hwdata", d0_HWDATA, bus.wdata);
      for (int m = 0; m < 2; m++) begin
         if (r[m]) begin
            if (dph[m].v && !dph[m].wr) chk("rnd_hrdata", rd[m], rd_fn(dph[m].addr));
            if (cur[m].v) begin
               chkb("rnd_pend_free", pend[m].v, 1'b0);
               pend[m] = cur[m];
            end
            dph[m] = cur[m];
            cur[m] = gen(1'(m), req_pct);
         end
      end
      if (HREADY) begin
         bus.v = 1'b0;
         if (htrans[1]) begin
            bm = int'(haddr[31]);
            chkb("rnd_bus_src", pend[bm].v, 1'b1);
            chk("rnd_bus_addr", haddr, pend[bm].addr);
            chkb("rnd_bus_write", hwrite, pend[bm].wr);
            chk("rnd_bus_size", 32'(hsize), 32'(pend[bm].size));
            if (pend[1-bm].v) begin
               skip[1-bm]++;
               chkb("rnd_rr_wait", skip[1-bm] <= 1, 1'b1);
            end
            skip[bm] = 0;
            gnt_log.push_back(bm);
            bus      = pend[bm];
            bus_m    = bm;
            pend[bm].v = 1'b0;
         end
      end
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn = 1'b0;
      HREADY  = 1'b1;
      HRDATA  = 32'h0;
      set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);
      chkb("rst_m0ready", d0_m0HREADY, 1'b1);
      chkb("rst_m1ready", d0_m1HREADY, 1'b1);
      chk("rst_htrans", 32'(d0_HTRANS), 32'(HTRANS_IDLE));
      chk("rst_haddr", d0_HADDR, 32'h0);
      chk("rst_hsize", 32'(d0_HSIZE), 32'h0);
      chkb("rst_hwrite", d0_HWRITE, 1'b0);
      chk("rst_fx_hsize", 32'(d1_HSIZE), 32'h0);
      chkb("rst_fx_m0ready", d1_m0HREADY, 1'b1);
      do_reset();

      // Solo DMA read
      set_m(1, HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 32'h0);
      @(negedge HCLK);
      chk("solo_haddr", d0_HADDR, 32'h2000_0000);
      chk("solo_htrans", 32'(d0_HTRANS), 32'(HTRANS_NONSEQ));
      chkb("solo_m1ready_a", d0_m1HREADY, 1'b1);
      chk("solo_fx_haddr", d1_HADDR, 32'h2000_0000);
      @(posedge HCLK); #1;
      set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      HRDATA = 32'hCAFE_0001;
      @(negedge HCLK);
      chk("solo_rdata", d0_m1HRDATA, 32'hCAFE_0001);
      chkb("solo_m1ready_d", d0_m1HREADY, 1'b1);
      chk("solo_fx_rdata", d1_m1HRDATA, 32'hCAFE_0001);
      chk("solo_fx_m0rdata", d1_m0HRDATA, 32'hCAFE_0001);
      @(posedge HCLK); #1;

      // Simultaneous requests: RR grants m0 first, fixed priority grants m1 first
      do_reset();
      set_m(0, HTRANS_NONSEQ, 32'h100, 1'b0, 32'h1111_1111);
      set_m(1, HTRANS_NONSEQ, 32'h200, 1'b1, 32'hDEAD_BEEF);
      @(negedge HCLK);
      chk("sim_rr_haddr0", d0_HADDR, 32'h100);
      chkb("sim_rr_hwrite0", d0_HWRITE, 1'b0);
      chk("sim_fx_haddr0", d1_HADDR, 32'h200);
      chkb("sim_fx_hwrite0", d1_HWRITE, 1'b1);
      @(posedge HCLK); #1;
      set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h1111_1111);
      set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'hDEAD_BEEF);
      @(negedge HCLK);
      chk("sim_rr_haddr1", d0_HADDR, 32'h200);
      chk("sim_rr_htrans1", 32'(d0_HTRANS), 32'(HTRANS_NONSEQ));
      chkb("sim_rr_hwrite1", d0_HWRITE, 1'b1);
      chkb("sim_rr_m1stall", d0_m1HREADY, 1'b0);
      chkb("sim_rr_m0ready", d0_m0HREADY, 1'b1);
      chk("sim_fx_haddr1", d1_HADDR, 32'h100);
      chk("sim_fx_htrans1", 32'(d1_HTRANS), 32'(HTRANS_NONSEQ));
      chkb("sim_fx_m0stall", d1_m0HREADY, 1'b0);
      chk("sim_fx_hwdata1", d1_HWDATA, 32'hDEAD_BEEF);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chkb("sim_rr_m1ready2", d0_m1HREADY, 1'b1);
      chk("sim_rr_hwdata2", d0_HWDATA, 32'hDEAD_BEEF);
      chk("sim_rr_htrans2", 32'(d0_HTRANS), 32'(HTRANS_IDLE));
      chkb("sim_fx_m0ready2", d1_m0HREADY, 1'b1);
      chk("sim_fx_hwdata2", d1_HWDATA, 32'h1111_1111);
      @(posedge HCLK); #1;

      // Slave wait states during m0's data phase while m1 requests
      do_reset();
      set_m(0, HTRANS_NONSEQ, 32'h300, 1'b0, 32'h0);
      @(posedge HCLK); #1;
      set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      set_m(1, HTRANS_NONSEQ, 32'h400, 1'b0, 32'h0);
      HREADY = 1'b0;
      @(negedge HCLK);
      chk("ws_htrans1", 32'(d0_HTRANS), 32'(HTRANS_IDLE));
      chkb("ws_m0ready1", d0_m0HREADY, 1'b0);
      chkb("ws_m1ready1", d0_m1HREADY, 1'b1);
      @(posedge HCLK); #1;
      set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);
      chkb("ws_m1stall2", d0_m1HREADY, 1'b0);
      chk("ws_haddr_held", d0_HADDR, 32'h300);
      chk("ws_htrans2", 32'(d0_HTRANS), 32'(HTRANS_IDLE));
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chkb("ws_fx_m1stall3", d1_m1HREADY, 1'b0);
      chk("ws_fx_htrans3", 32'(d1_HTRANS), 32'(HTRANS_IDLE));
      @(posedge HCLK); #1;
      HREADY = 1'b1;
      @(negedge HCLK);
      chk("ws_haddr4", d0_HADDR, 32'h400);
      chk("ws_htrans4", 32'(d0_HTRANS), 32'(HTRANS_NONSEQ));
      chkb("ws_m0ready4", d0_m0HREADY, 1'b1);
      chkb("ws_m1stall4", d0_m1HREADY, 1'b0);
      chk("ws_fx_haddr4", d1_HADDR, 32'h400);
      @(posedge HCLK); #1;

      // Reset while a captured request is held
      do_reset();
      set_m(0, HTRANS_NONSEQ, 32'h500, 1'b0, 32'h0);
      set_m(1, HTRANS_NONSEQ, 32'h600, 1'b0, 32'h0);
      @(posedge HCLK); #1;
      set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
      @(negedge HCLK);
      chkb("rh_m1held", d0_m1HREADY, 1'b0);
      chkb("rh_fx_m0held", d1_m0HREADY, 1'b0);
      #1 HRESETn = 1'b0;
      #1;
      chkb("rh_async_m1ready", d0_m1HREADY, 1'b1);
      chk("rh_async_htrans", 32'(d0_HTRANS), 32'(HTRANS_IDLE));
      chk("rh_async_haddr", d0_HADDR, 32'h0);
      chkb("rh_async_fx_m0ready", d1_m0HREADY, 1'b1);
      @(posedge HCLK); #1 HRESETn = 1'b1;
      @(negedge HCLK);
      chkb("rh_post_m1ready", d0_m1HREADY, 1'b1);
      chk("rh_post_htrans", 32'(d0_HTRANS), 32'(HTRANS_IDLE));
      chk("rh_post_fx_htrans", 32'(d1_HTRANS), 32'(HTRANS_IDLE));
      @(posedge HCLK); #1;

      // Round-robin fairness with both masters requesting continuously
      do_reset();
      eng_init(100);
      gnt_log.delete();
      repeat (8) step(100, 100);
      chk("rr_count", 32'(gnt_log.size()), 32'd8);
      for (int i = 0; i < gnt_log.size(); i++)
         chk("rr_order", 32'(gnt_log[i]), 32'(i % 2));

      // Random traffic with slave wait states, then drain
      for (int i = 0; i < 600; i++) step(60, 70);
      repeat (12) step(0, 100);
      chkb("drain_pend0", pend[0].v, 1'b0);
      chkb("drain_pend1", pend[1].v, 1'b0);
      chkb("drain_bus", bus.v, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahbl_master_mux2.md
# ahbl_master_mux2

Two-master AHB-Lite arbiter and multiplexer that lets the CPU and the DMA controller's master port share a single AHB-Lite bus. It sits directly downstream of the DMA controller's master interface (mH*) and upstream of the system address decoder and slave mux. Each master sees a private AHB-Lite port. A losing master's address phase is captured and it is stalled via its own HREADY. Data-phase signals are steered by a registered data-phase owner.

## Interface
- PRIO_MODE, default 0: 0 = round-robin (last-granted loses a tie); 1 = fixed priority, m1 (DMA) wins ties.
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- m0HADDR / m1HADDR  in  32  master address (m0 = CPU, m1 = DMA).
- m0HTRANS / m1HTRANS  in  2  transfer type; bit1 = request.
- m0HSIZE / m1HSIZE  in  3  transfer size.
- m0HWRITE / m1HWRITE  in  1  write strobe.
- m0HWDATA / m1HWDATA  in  32  write data, data phase.
- m0HREADY / m1HREADY  out  1  per-master ready.
- m0HRDATA / m1HRDATA  out  32  read data, broadcast from HRDATA.
- HADDR  out  32  shared bus address.
- HTRANS  out  2  shared bus transfer type.
- HSIZE  out  3  shared bus size.
- HWRITE  out  1  shared bus write strobe.
- HWDATA  out  32  shared bus write data.
- HREADY  in  1  bus ready (selected slave's HREADYOUT).
- HRDATA  in  32  bus read data.

## Operation
- Per-master state:
  - hold_valid
  - hold_{addr, size, write}
- Global state:
  - dph_valid
  - dph_owner (0/1)
  - last_grant (0/1)
- Request for master m: req[m] = hold_valid[m] | (mHTRANS[1] & mHREADY_out[m]).
- Grant is evaluated only when HREADY = 1.
  - One requester: it wins.
  - Two requesters: PRIO_MODE decides.
  - The winner's address phase drives HADDR/HSIZE/HWRITE, from the hold register if hold_valid, else live and combinational.
- HTRANS output:
  - Live grant: master's HTRANS passed through.
  - Grant from hold register: always NONSEQ (2'b10); an interrupted burst is restarted.
  - No grant, or HREADY = 0: HTRANS = IDLE.
  - While HREADY = 0, the output address phase is held from registered copies (out_addr/size/write/trans_r).
- Capture: a live request from m that is not granted while HREADY = 1 is loaded into hold_*[m], and hold_valid[m] ← 1. A request seen while HREADY = 0 is also captured.
- hold_valid[m] clears on the edge its held transfer is granted.
- On every edge with HREADY = 1:
  - dph_valid ← any grant
  - dph_owner ← grant
  - last_grant ← grant (only if a grant occurred)
- mHREADY_out[m], in priority order:
  1. dph_valid & dph_owner==m → HREADY
  2. hold_valid[m] → 0
  3. otherwise → 1
- HWDATA = dph_owner ? m1HWDATA : m0HWDATA. Masters hold write data while stalled.
- Boundary cases:
  - hold_valid and data-phase ownership never coexist for one master.
  - A master stalling in its data phase blocks all grants.
  - Back-to-back requests from one master with no contender: full throughput, zero added latency.
  - No HRESP/error path.

## Timing
- Reset values:
  - all hold_valid = 0, dph_valid = 0, last_grant = 1 (m0 wins the first RR tie)
  - m0HREADY = m1HREADY = 1
  - HTRANS = IDLE, HADDR = 0, HSIZE = 0, HWRITE = 0
- Reset mid-transfer discards hold and data-phase state immediately; outputs return to reset values asynchronously.
- Granted live request: 0 cycles added latency.
- Captured request: granted no earlier than the next HREADY-high cycle. The master sees mHREADY = 0 from the cycle after capture until its data phase completes.
- Minimum added latency for a captured request: 1 cycle, with an uncontended single-cycle slave.

## Structure
- Shared package ahbl_pkg holds:
  - HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11
  - PRIO_RR = 0, PRIO_FIXED = 1
- Sub-module ahbl_hold_stage: capture register plus hold_valid for one master, instantiated twice.
- Grant logic, data-phase tracking and muxing stay in the top level.

## Test plan
- Solo DMA: m1 issues NONSEQ read at 0x2000_0000, m0 IDLE → HADDR = 0x2000_0000 same cycle; m1HRDATA = HRDATA next cycle; m1HREADY never low.
- Simultaneous, PRIO_MODE = 0 after reset:
  - m0 reads 0x100 and m1 writes 0x200 in the same cycle → m0 granted first (last_grant = 1).
  - Next cycle HADDR = 0x200, HTRANS = NONSEQ, m1HREADY = 0 for exactly 1 cycle.
  - HWDATA = m1HWDATA in the following cycle.
- PRIO_MODE = 1, same stimulus → m1 granted first; m0 captured and granted next cycle.
- Slave wait states: HREADY low 3 cycles during m0's data phase while m1 requests → HTRANS = IDLE (or held), no grant change; m1 granted on the first HREADY-high edge.
- Round-robin fairness: both masters request continuously for 8 transfers → grants alternate 0,1,0,1…; no master waits more than 1 transfer.
- Reset asserted while m1 holds a captured request → after release, m1HREADY = 1, HTRANS = IDLE, hold discarded.
